// File: rtl/adder_pipe_unit_pkg.sv
// Shared constants and types for the registered reference adder.
package adder_pipe_unit_pkg;

  // Operand/sum width used when the instantiating code does not override it.
  localparam int ADDER_DEFAULT_WIDTH = 8;

  // Every flop in the adder (input stage and output register) resets to zeros.
  localparam logic ADDER_RST_BIT = 1'b0;

  // {cout, s} at the default width; carry-out sits in the MSB.
  typedef logic [ADDER_DEFAULT_WIDTH:0] adder_result_t;

endpackage : adder_pipe_unit_pkg

// File: rtl/adder_pipe_unit_full_adder_cell.sv
// One-bit combinational full adder; the ripple chain is built from these.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ ci;
  // Generate when both operands are 1, propagate the incoming carry otherwise.
  assign co       = (a & b) | (ci & half_sum);

endmodule : full_adder_cell

// File: rtl/adder_pipe_unit.sv
// Registered WIDTH-bit ripple-carry adder with optional input register stage.
// Latency is 1 cycle (REG_IN=0) or 2 cycles (REG_IN=1); outputs come straight
// from flops so downstream pin comparisons never see combinational glitches.
module adder_pipe_unit
  import adder_pipe_unit_pkg::*;
#(
  parameter int WIDTH  = ADDER_DEFAULT_WIDTH,
  parameter bit REG_IN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // Operand bundle so the optional input stage is a single register.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } operand_t;

  typedef logic [WIDTH:0] result_t;

  localparam operand_t OPERAND_RST = {$bits(operand_t){ADDER_RST_BIT}};
  localparam result_t  RESULT_RST  = {$bits(result_t){ADDER_RST_BIT}};

  operand_t op_in;
  operand_t op_use;

  assign op_in = '{a: a, b: b, cin: cin};

  // ---------------------------------------------------------------------------
  // Optional input stage
  // ---------------------------------------------------------------------------
  if (REG_IN) begin : g_in_reg
    operand_t op_d;
    operand_t op_q;

    // Capture the raw operands every edge; no enable, no handshake.
    always_comb begin
      op_d = op_in;
    end

    // Input-stage register; reset discards any operand in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_q <= OPERAND_RST;
      end else begin
        op_q <= op_d;
      end
    end

    assign op_use = op_q;
  end else begin : g_in_pass
    assign op_use = op_in;
  end

  // ---------------------------------------------------------------------------
  // Ripple-carry chain: cin enters bit 0, carry-out leaves bit WIDTH-1.
  // Each stage owns its carry wires so the chain is a plain feed-forward path.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_bits;
  logic             carry_out;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    logic ci_w;
    logic co_w;

    if (i == 0) begin : g_first
      assign ci_w = op_use.cin;
    end else begin : g_next
      assign ci_w = g_ripple[i-1].co_w;
    end

    full_adder_cell u_fa (
      .a  (op_use.a[i]),
      .b  (op_use.b[i]),
      .ci (ci_w),
      .s  (sum_bits[i]),
      .co (co_w)
    );
  end

  assign carry_out = g_ripple[WIDTH-1].co_w;

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  result_t sum_d;
  result_t sum_q;

  // Assemble {cout, s} from the chain for the output register.
  // NOTE: every always_comb output gets a value on every path (here a default
  // first) so no latch is inferred if the block later grows conditions.
  always_comb begin
    sum_d = RESULT_RST;
    sum_d = {carry_out, sum_bits};
  end

  // Output register; asynchronous clear drives s/cout to 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= RESULT_RST;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign s    = sum_q[WIDTH-1:0];
  assign cout = sum_q[WIDTH];

endmodule : adder_pipe_unit

// File: tb/tb_adder_pipe_unit.sv
// Scoreboard bench for adder_pipe_unit: one REG_IN=0 and one REG_IN=1 instance
// share the same stimulus; expected results are queued with the cycle at which
// each instance must present them, and a monitor pops and compares.
module tb_adder_pipe_unit;
  import adder_pipe_unit_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] s0;
  logic       cout0;
  logic [7:0] s1;
  logic       cout1;

  int unsigned cyc     = 0;
  int          n_check = 0;
  int          n_fail  = 0;

  typedef struct {
    int unsigned   due;
    adder_result_t exp;
    string         tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  adder_pipe_unit #(.WIDTH(8), .REG_IN(1'b0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s0),
    .cout (cout0)
  );

  adder_pipe_unit #(.WIDTH(8), .REG_IN(1'b1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s1),
    .cout (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input adder_result_t act, input adder_result_t exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got cout=%b s=%h, expected cout=%b s=%h at cycle %0d",
               name, act[8], act[7:0], exp[8], exp[7:0], cyc);
    end
  endtask

  // Drive operands and queue the result each instance owes for them.
  task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input adder_result_t ex, input string tag);
    a   = av;
    b   = bv;
    cin = ci;
    q0.push_back('{due: cyc + 1, exp: ex, tag: tag});
    q1.push_back('{due: cyc + 2, exp: ex, tag: tag});
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_check, n_fail);
  endtask

  // Monitor: after each rising edge compare whatever is due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        check({e.tag, "_lat1"}, {cout0, s0}, e.exp);
      end
      while (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        check({e.tag, "_lat2"}, {cout1, s1}, e.exp);
      end
    end
  end

  // Directed vectors with hand-computed {cout, s}.
  typedef struct {
    logic [7:0]    av;
    logic [7:0]    bv;
    logic          ci;
    adder_result_t ex;
    string         tag;
  } vec_t;

  vec_t dir_tab[11] = '{
    '{8'h00, 8'h00, 1'b0, 9'h000, "zero"},
    '{8'h00, 8'h00, 1'b1, 9'h001, "zero_cin"},
    '{8'hFF, 8'h01, 1'b0, 9'h100, "wrap_ff_01"},
    '{8'hFF, 8'hFF, 1'b1, 9'h1FF, "wrap_ff_ff_c"},
    '{8'h80, 8'h80, 1'b0, 9'h100, "msb_80_80"},
    '{8'hAA, 8'h55, 1'b0, 9'h0FF, "alt_no_c"},
    '{8'hAA, 8'h55, 1'b1, 9'h100, "alt_c_ripple"},
    '{8'h7F, 8'h01, 1'b0, 9'h080, "half_carry"},
    '{8'h01, 8'hFE, 1'b1, 9'h100, "full_ripple"},
    '{8'h3C, 8'hC3, 1'b0, 9'h0FF, "compl"},
    '{8'h12, 8'h34, 1'b0, 9'h046, "plain"}
  };

  logic [7:0] b_tab[8] = '{8'h00, 8'h01, 8'h0F, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF};

  // Driver
  initial begin
    adder_result_t ex;
    logic [7:0]    av;
    bit            rel_chk;

    rst_n = 1'b0;
    a     = 8'h55;
    b     = 8'h0F;
    cin   = 1'b1;

    // Reset held across clocks: both instances stay at zero.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_r0", {cout0, s0}, 9'h000);
      check("rst_hold_r1", {cout1, s1}, 9'h000);
    end

    // Release: first edge gives 0x55+0x0F+1 on the latency-1 instance.
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h55, 8'h0F, 1'b1, 9'h065, "rst_release");
    @(posedge clk);
    #1;
    check("rel_first_edge_r1", {cout1, s1}, 9'h000);

    foreach (dir_tab[i]) begin
      @(negedge clk);
      apply(dir_tab[i].av, dir_tab[i].bv, dir_tab[i].ci, dir_tab[i].ex, dir_tab[i].tag);
    end

    // Sweep a over 0x00-0xFF against a set of b values, cin = 0. Inputs are
    // scrambled between edges; only the value at the rising edge counts.
    rel_chk = 1'b0;
    foreach (b_tab[bi]) begin
      for (int ai = 0; ai < 256; ai++) begin
        av = 8'(ai);
        ex = {1'b0, av} + {1'b0, b_tab[bi]};
        @(negedge clk);
        rst_n = 1'b1;
        apply(av, b_tab[bi], 1'b0, ex, "sweep");
        @(posedge clk);
        #1;
        if (rel_chk) begin
          check("mid_rel_first_edge_r1", {cout1, s1}, 9'h000);
          rel_chk = 1'b0;
        end
        #1;
        a   = ~av;
        b   = ~b_tab[bi];
        cin = 1'b1;
        if (bi == 3 && ai == 100) begin
          // Asynchronous reset between edges: outputs clear before next edge.
          rst_n = 1'b0;
          q0.delete();
          q1.delete();
          #1;
          check("mid_rst_async_r0", {cout0, s0}, 9'h000);
          check("mid_rst_async_r1", {cout1, s1}, 9'h000);
          rel_chk = 1'b1;
        end
      end
    end

    // Let the latency-2 instance drain, then everything owed must be seen.
    repeat (4) @(negedge clk);
    check("drain", adder_result_t'(q0.size() + q1.size()), 9'h000);

    summary();
    $finish;
  end

  // Watchdog: a stuck run still reports and terminates.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $finish;
  end

endmodule : tb_adder_pipe_unit

// File: doc/adder_pipe_unit.md
Name: adder_pipe_unit

Overview:
- Registered WIDTH-bit binary adder with carry-in and carry-out; default width is 8 bits.
- Used as the reference datapath block. Its registered outputs provide the golden values for the fabric output pins during configured-fabric simulation.
- Structure: combinational ripple-carry sum of a + b + cin, captured in an output register on the rising clk edge.
- An optional input register stage adds one cycle of latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range ≥ 1).
- REG_IN, 0, 1 inserts an input register stage on a, b and cin (total latency 2 cycles); 0 gives latency 1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- s  output  WIDTH  registered sum, low WIDTH bits of a + b + cin.
- cout  output  1  registered carry-out, bit WIDTH of a + b + cin.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Assertion clears state immediately, independent of clk. Deassertion takes effect at the next rising edge.
- Reset values: s = 0 and cout = 0. When REG_IN=1, the input-stage registers also reset to 0.
- Arithmetic: {cout, s} = a + b + cin computed at WIDTH+1 bits, unsigned. No overflow flag. Wrap-around shows only as cout = 1 with s holding the low bits.
- REG_IN=0 latency: s/cout at edge k+1 reflect a, b, cin sampled at edge k+1. Outputs are valid immediately after the edge following an input change.
- REG_IN=1 latency: inputs are captured at edge k and results appear after edge k+1.
- Handshake: none. Every edge out of reset produces a new result. Outputs hold between edges.
- Inputs may change at any time relative to the clock; only values at the rising edge matter.
- Reset mid-operation: outputs go to 0 asynchronously and all in-flight stages are discarded. The first valid result appears 1 cycle (REG_IN=0) or 2 cycles (REG_IN=1) after the first edge with rst_n = 1.
- Carry chain: explicit ripple of full-adder cells, bit 0 first with cin into bit 0 and cout taken from cell WIDTH-1. Functionally identical to the + operator.
- Outputs are glitch-free, being driven directly from flops.

Decomposition:
- Shared package holds:
  - ADDER_DEFAULT_WIDTH = 8
  - the reset-value constant (all zeros)
  - a typedef for the WIDTH+1 result vector, used by the top and by bench scoreboards.
- One natural sub-module: full_adder_cell, a 1-bit combinational full adder (a, b, ci → s, co), instantiated WIDTH times in a generate loop.
- Registers and the optional input stage stay in the top module.

Test Plan:
- Reset: hold rst_n = 0 with a = 0x55, b = 0x0F, cin = 1 and apply clocks → s = 0x00, cout = 0 throughout. Release, then 1 edge → s = 0x65, cout = 0.
- Zero and identity: a = 0x00, b = 0x00, cin = 0 → s = 0x00, cout = 0. Then cin = 1 → s = 0x01, cout = 0.
- Wrap-around boundary:
  - a = 0xFF, b = 0x01, cin = 0 → s = 0x00, cout = 1.
  - a = 0xFF, b = 0xFF, cin = 1 → s = 0xFF, cout = 1.
- Exhaustive sweep: a and b each over 0x00–0xFF with cin held 0, new values each half clock period. Each sampled result must match the model {cout, s} = a + b + cin with latency 1.
- Asynchronous reset mid-stream: during the sweep, pulse rst_n low between clock edges. Outputs drop to 0 before the next edge, then resume correct values 1 edge after release.
- REG_IN=1 build: a = 0x80, b = 0x80, cin = 0 applied at edge k → s = 0x00, cout = 1 visible only after edge k+1. Outputs at edge k still show the prior result.
